// File: rtl/sdf_r2_butterfly_stage.sv
// Radix-2 single-delay-feedback DIF butterfly stage.
// Sums stream out during the second half-frame; differences are parked in the
// feedback delay line and replayed, twiddle-tagged, during the next first half-frame.
module sdf_r2_butterfly_stage #(
  parameter int unsigned INTEGER_SIZE = 7,
  parameter int unsigned FRACT_SIZE   = 11,
  parameter int unsigned DELAY        = 32,
  localparam int unsigned DATA_WIDTH  = INTEGER_SIZE + FRACT_SIZE,
  localparam int unsigned CNT_W       = $clog2(2 * DELAY),
  localparam int unsigned ADDR_W      = CNT_W - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic                  tw_en,
  output logic [ADDR_W-1:0]     tw_addr
);

  localparam int unsigned W = DATA_WIDTH;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              primed_q, primed_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_r_q, out_r_d;
  logic [W-1:0]      out_i_q, out_i_d;
  logic              tw_en_q, tw_en_d;
  logic [ADDR_W-1:0] tw_addr_q, tw_addr_d;

  logic [W-1:0] dl_r_q [DELAY];
  logic [W-1:0] dl_i_q [DELAY];
  logic [W-1:0] dl_r_d [DELAY];
  logic [W-1:0] dl_i_d [DELAY];

  logic         phase;
  logic [W-1:0] head_r, head_i;
  logic [W:0]   sum_r_w, sum_i_w, dif_r_w, dif_i_w;
  logic [W-1:0] dl_in_r, dl_in_i;

  assign phase  = cnt_q[CNT_W-1];
  assign head_r = dl_r_q[DELAY-1];
  assign head_i = dl_i_q[DELAY-1];

  // Butterfly arithmetic at W+1 bits; taking [W:1] is the floor shift by one.
  always_comb begin
    sum_r_w = {head_r[W-1], head_r} + {in_r[W-1], in_r};
    sum_i_w = {head_i[W-1], head_i} + {in_i[W-1], in_i};
    dif_r_w = {head_r[W-1], head_r} - {in_r[W-1], in_r};
    dif_i_w = {head_i[W-1], head_i} - {in_i[W-1], in_i};
  end

  // Next-state for counter, priming flag and output registers.
  always_comb begin
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    tw_en_d     = tw_en_q;
    tw_addr_d   = tw_addr_q;
    dl_in_r     = in_r;
    dl_in_i     = in_i;
    if (in_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(2 * DELAY - 1)) begin
        primed_d = 1'b1;
      end
      if (phase) begin
        dl_in_r     = dif_r_w[W:1];
        dl_in_i     = dif_i_w[W:1];
        out_valid_d = 1'b1;
        out_r_d     = sum_r_w[W:1];
        out_i_d     = sum_i_w[W:1];
        tw_en_d     = 1'b0;
        tw_addr_d   = '0;
      end else if (primed_q) begin
        // Head holds the previous frame's difference for index cnt.
        out_valid_d = 1'b1;
        out_r_d     = head_r;
        out_i_d     = head_i;
        tw_en_d     = 1'b1;
        tw_addr_d   = cnt_q[ADDR_W-1:0];
      end
    end
  end

  // Delay-line shift: entry 0 is newest, entry DELAY-1 is the head.
  always_comb begin
    for (int i = 0; i < DELAY; i++) begin
      dl_r_d[i] = dl_r_q[i];
      dl_i_d[i] = dl_i_q[i];
    end
    if (in_valid) begin
      dl_r_d[0] = dl_in_r;
      dl_i_d[0] = dl_in_i;
      for (int i = 1; i < DELAY; i++) begin
        dl_r_d[i] = dl_r_q[i-1];
        dl_i_d[i] = dl_i_q[i-1];
      end
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      tw_en_q     <= 1'b0;
      tw_addr_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      tw_en_q     <= tw_en_d;
      tw_addr_q   <= tw_addr_d;
    end
  end

  // Delay-line storage; stale contents are masked by primed, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DELAY; i++) begin
      dl_r_q[i] <= dl_r_d[i];
      dl_i_q[i] <= dl_i_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign tw_en     = tw_en_q;
  assign tw_addr   = tw_addr_q;

endmodule

// File: tb/tb_sdf_r2_butterfly_stage.sv
// Bench for sdf_r2_butterfly_stage: a DELAY=4 and a DELAY=32 instance share one
// input stream; each is checked every cycle against a frame-level reference model.
module tb_sdf_r2_butterfly_stage;

  localparam int W   = 18;
  localparam int D4  = 4;
  localparam int D32 = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_r = '0;
  logic [W-1:0] in_i = '0;

  logic         ov4, te4, ov32, te32;
  logic [W-1:0] or4, oi4, or32, oi32;
  logic [1:0]   ta4;
  logic [4:0]   ta32;

  always #5 clk = ~clk;

  sdf_r2_butterfly_stage #(.INTEGER_SIZE(7), .FRACT_SIZE(11), .DELAY(D4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .out_valid(ov4), .out_r(or4), .out_i(oi4), .tw_en(te4), .tw_addr(ta4)
  );

  sdf_r2_butterfly_stage #(.INTEGER_SIZE(7), .FRACT_SIZE(11), .DELAY(D32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .out_valid(ov32), .out_r(or32), .out_i(oi32), .tw_en(te32), .tw_addr(ta32)
  );

  int total = 0;
  int bad   = 0;

  // Accepted samples since the last reset, in arrival order.
  int hr[$];
  int hi[$];

  // Expected (held) outputs per instance: index 0 -> DELAY=4, 1 -> DELAY=32.
  int e_v[2];
  int e_r[2];
  int e_i[2];
  int e_tw[2];
  int e_ad[2];

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Frame-level rule: sample m at position j of its 2D frame.
  //   j >= D : sum of x[m-D] and x[m], halved (floor), untagged.
  //   j <  D : difference of the previous frame's pair, halved, tagged k=j.
  task automatic predict(input int k, input int d);
    int m, j;
    m = hr.size() - 1;
    j = m % (2 * d);
    if (j >= d) begin
      e_v[k]  = 1;
      e_r[k]  = (hr[m-d] + hr[m]) >>> 1;
      e_i[k]  = (hi[m-d] + hi[m]) >>> 1;
      e_tw[k] = 0;
      e_ad[k] = 0;
    end else if (m >= 2 * d) begin
      e_v[k]  = 1;
      e_r[k]  = (hr[m-2*d] - hr[m-d]) >>> 1;
      e_i[k]  = (hi[m-2*d] - hi[m-d]) >>> 1;
      e_tw[k] = 1;
      e_ad[k] = j;
    end else begin
      e_v[k] = 0;
    end
  endtask

  task automatic model(input bit rs, input bit v, input int r, input int i);
    if (!rs) begin
      hr.delete();
      hi.delete();
      for (int k = 0; k < 2; k++) begin
        e_v[k] = 0; e_r[k] = 0; e_i[k] = 0; e_tw[k] = 0; e_ad[k] = 0;
      end
    end else if (v) begin
      hr.push_back(r);
      hi.push_back(i);
      predict(0, D4);
      predict(1, D32);
    end else begin
      e_v[0] = 0;
      e_v[1] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/d4.valid"},  32'(ov4),           e_v[0]);
    chk({tag, "/d4.r"},      32'($signed(or4)),  e_r[0]);
    chk({tag, "/d4.i"},      32'($signed(oi4)),  e_i[0]);
    chk({tag, "/d4.tw_en"},  32'(te4),           e_tw[0]);
    chk({tag, "/d4.addr"},   32'(ta4),           e_ad[0]);
    chk({tag, "/d32.valid"}, 32'(ov32),          e_v[1]);
    chk({tag, "/d32.r"},     32'($signed(or32)), e_r[1]);
    chk({tag, "/d32.i"},     32'($signed(oi32)), e_i[1]);
    chk({tag, "/d32.tw_en"}, 32'(te32),          e_tw[1]);
    chk({tag, "/d32.addr"},  32'(ta32),          e_ad[1]);
  endtask

  task automatic step(input bit rs, input bit v, input int r, input int i, input string tag);
    rst      = rs;
    in_valid = v;
    in_r     = W'(r);
    in_i     = W'(i);
    @(posedge clk);
    #1;
    model(rs, v, r, i);
    check_all(tag);
  endtask

  function automatic int rnd18();
    logic [W-1:0] t;
    t = W'($urandom);
    return int'($signed(t));
  endfunction

  int n;

  initial begin
    // Reset state.
    step(1'b0, 1'b0, 0, 0, "reset");
    step(1'b0, 1'b1, 777, 5, "reset_hold");

    // Impulse then a zero frame.
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, (k == 0) ? 2048 : 0, 0, "impulse_f1");
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 0, 0, "impulse_f2");

    // DC for three frames.
    for (int k = 0; k < 24; k++) step(1'b1, 1'b1, 2048, 0, "dc");

    // Extreme pairs; then flush.
    step(1'b1, 1'b1,  131071,  131071, "ext");
    step(1'b1, 1'b1, -131072, -131072, "ext");
    step(1'b1, 1'b1,  131071, -131072, "ext");
    step(1'b1, 1'b1, -131072,  131071, "ext");
    step(1'b1, 1'b1,  131071,  131071, "ext");
    step(1'b1, 1'b1, -131072, -131072, "ext");
    step(1'b1, 1'b1, -131072,  131071, "ext");
    step(1'b1, 1'b1,  131071, -131072, "ext");
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 0, 0, "ext_flush");

    // Impulse with random stalls; stalled cycles carry garbage data.
    step(1'b0, 1'b0, 0, 0, "stall_rst");
    n = 0;
    while (n < 16) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1'b1, 1'b1, (n == 0) ? 2048 : 0, 0, "stall_imp");
        n++;
      end else begin
        step(1'b1, 1'b0, rnd18(), rnd18(), "stall_gap");
      end
    end

    // Reset at cnt=5 of frame 2, then the impulse test again.
    step(1'b0, 1'b0, 0, 0, "mid_rst_pre");
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, (k == 0) ? 2048 : 0, 0, "mid_f1");
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 0, 0, "mid_f2");
    step(1'b0, 1'b0, 0, 0, "mid_rst");
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, (k == 0) ? 2048 : 0, 0, "mid_imp_f1");
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 0, 0, "mid_imp_f2");

    // 64-sample ramp over three frames, then zero flush.
    step(1'b0, 1'b0, 0, 0, "ramp_rst");
    for (int k = 0; k < 192; k++) step(1'b1, 1'b1, (k % 64) * 16, -(k % 64) * 8, "ramp");
    for (int k = 0; k < 32; k++) step(1'b1, 1'b1, 0, 0, "ramp_flush");

    // Random data with random stalls.
    for (int k = 0; k < 200; k++) begin
      step(1'b1, ($urandom_range(0, 3) != 0), rnd18(), rnd18(), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdf_r2_butterfly_stage.md
Name: sdf_r2_butterfly_stage

Overview:
Radix-2 single-delay-feedback (SDF) decimation-in-frequency butterfly stage of the 64-point streaming FFT. It sits directly upstream of the twiddle complex multiplier and pairs samples DELAY apart through an internal feedback delay line. Sums stream out immediately. Differences are stored, then emitted during the next half-frame, flagged for twiddle multiplication with the matching twiddle index. Data format is the same signed fixed-point as the datapath: INTEGER_SIZE integer bits plus FRACT_SIZE fraction bits.

Parameters:
INTEGER_SIZE, 7, integer bits of the signed fixed-point sample
FRACT_SIZE, 11, fraction bits; DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE (localparam)
DELAY, 32, feedback delay depth = half the stage span (power of 2, >=2); CNT_W = log2(2*DELAY) (localparam)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  reset, synchronous, active-low
in_valid  in  1  input sample present this cycle
in_r  in  DATA_WIDTH  input real, signed
in_i  in  DATA_WIDTH  input imag, signed
out_valid  out  1  output sample valid
out_r  out  DATA_WIDTH  output real, signed
out_i  out  DATA_WIDTH  output imag, signed
tw_en  out  1  output is a difference term and must be twiddle-multiplied
tw_addr  out  log2(DELAY)  twiddle index k (W_2DELAY^k) for the current output

Behaviour:
- Reset: synchronous, active-low; clk and rst named as across the datapath. Reset is sampled at posedge when rst=0.
- Reset values: cnt=0, primed=0, out_valid=0, out_r=out_i=0, tw_en=0, tw_addr=0. Delay-line contents need not be cleared; primed masks them.
- Reset mid-frame: the partial frame is discarded. The first sample after reset is n=0 of a new frame.
- Sample counter cnt (CNT_W bits) advances only on in_valid. It wraps from 2*DELAY-1 to 0. phase = cnt[CNT_W-1].
- Delay line: DELAY complex entries. It shifts/advances only on in_valid; in_valid=0 freezes all state (stall). Let head = the oldest entry.
- phase 0 (cnt < DELAY):
  - delay line takes input x.
  - output = head, which is the stored difference from the previous frame.
  - tw_en=1, tw_addr = cnt[CNT_W-2:0].
- phase 1 (cnt >= DELAY):
  - a=head, b=x.
  - output = (a+b)>>>1; delay line takes (a-b)>>>1.
  - tw_en=0, tw_addr=0.
- Arithmetic: add/sub is done at DATA_WIDTH+1 bits, then arithmetic right shift by 1 (floor), which gives exactly DATA_WIDTH bits. Overflow is impossible and there is no saturation. Real and imag parts are independent.
- Latency: all outputs are registered. The output for the sample accepted at edge t is visible after edge t, i.e. one cycle.
- out_valid = registered (in_valid & (phase==1 | primed)).
- primed: set on the first wrap of cnt from 2*DELAY-1 to 0; cleared only by reset. First-frame phase-0 outputs are therefore suppressed (out_valid=0).
- When out_valid=0, out_r/out_i/tw_en/tw_addr hold their previous values.
- Tail: the last frame's differences emerge only while the next frame's inputs arrive. Upstream pushes DELAY zero samples to flush.
- Output order per frame: DELAY sums (k=0..DELAY-1), then DELAY twiddle-tagged differences (k=0..DELAY-1). This matches downstream multiplier expectations. The multiplier's 2-cycle latency is absorbed downstream.

Test Plan (DELAY=4 unless noted; 1.0 = 2048):
1. Impulse: frame 1 x0=2048 real, rest 0, then frame 2 all zeros -> frame-1 phase-1 outputs 1024,0,0,0 with tw_en=0; frame-2 phase-0 outputs 1024,0,0,0 with tw_en=1, tw_addr 0,1,2,3; no out_valid during frame-1 phase 0.
2. DC: all samples 2048+j0 for 3 frames -> every sum output 2048, every difference output 0, out_valid one cycle after each in_valid once primed.
3. Extremes: a=131071 paired with b=131071 -> sum 131071. a=-131072, b=-131072 -> sum -131072. a=131071, b=-131072 -> stored diff 131071. No wrap.
4. Stall: repeat test 1 with in_valid toggling pseudo-randomly -> identical out_* / tw_* sequence on out_valid cycles; cnt and data frozen on stall cycles.
5. Reset mid-frame: assert rst=0 for one cycle at cnt=5 of frame 2 -> outputs return to 0, out_valid=0 next cycle; the next valid input is treated as n=0 with primed=0, and test 1 is reproduced exactly.
6. DELAY=32 build: 64-sample ramp real=n*16 -> sums (2n+32)*16/2 ... checked against a bit-exact software model over 3 frames.
